// File: rtl/hack_ps2_keyboard.sv
`default_nettype none
// ============================================================================
//  Module      : hack_ps2_keyboard
//  Description : PS/2 keyboard receiver for the Hack KBD register.
//                Synchronises and filters the PS/2 lines, assembles
//                11-bit frames, and decodes scan code set 2 make/break/E0
//                sequences. It presents the Hack key code of the held key,
//                or 0 when no key is down. Receive only: it never drives
//                the PS/2 lines.
//  Ports       : clk         - system clock
//                reset       - asynchronous active-high reset
//                ps2_clk     - raw PS/2 clock from the device (async)
//                ps2_data    - raw PS/2 data from the device (async)
//                key_code    - Hack code of the held key, 0 = none
//                frame_error - one-cycle pulse on parity, framing or
//                              timeout error
//  Revision    : 1.0 - initial release
// ============================================================================
module hack_ps2_keyboard #(
  parameter int WIDTH          = 16,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ps2_clk,
  input  logic             ps2_data,
  output logic [WIDTH-1:0] key_code,
  output logic             frame_error
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic             clk_s1_q, clk_s2_q;
  logic             dat_s1_q, dat_s2_q;
  logic             clk_filt_q, clk_filt_d;
  logic [FW-1:0]    filt_cnt_q, filt_cnt_d;
  state_t           state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             parity_q, parity_d;
  logic [TW-1:0]    to_cnt_q, to_cnt_d;
  logic             byte_valid_q, byte_valid_d;
  logic             frame_error_q, frame_error_d;
  logic             ext_q, ext_d;
  logic             brk_q, brk_d;
  logic [WIDTH-1:0] key_code_q, key_code_d;

  logic             fall;
  logic [7:0]       mapped;
  logic [WIDTH-1:0] mapped_ext;

  // --------------------------------------------------------------------------
  // Scan code set 2 to Hack key code. Unlisted codes give 0.
  // --------------------------------------------------------------------------
  function automatic logic [7:0] map_code(input logic ext, input logic [7:0] sc);
    logic [7:0] r;
    r = 8'd0;
    if (ext) begin
      case (sc)
        8'h6B: r = 8'd130;  // Left
        8'h75: r = 8'd131;  // Up
        8'h74: r = 8'd132;  // Right
        8'h72: r = 8'd133;  // Down
        8'h6C: r = 8'd134;  // Home
        8'h69: r = 8'd135;  // End
        8'h7D: r = 8'd136;  // PgUp
        8'h7A: r = 8'd137;  // PgDn
        8'h70: r = 8'd138;  // Insert
        8'h71: r = 8'd139;  // Delete
        8'h5A: r = 8'd128;  // keypad Enter
        default: r = 8'd0;
      endcase
    end else begin
      case (sc)
        8'h1C: r = 8'd65;  8'h32: r = 8'd66;  8'h21: r = 8'd67;
        8'h23: r = 8'd68;  8'h24: r = 8'd69;  8'h2B: r = 8'd70;
        8'h34: r = 8'd71;  8'h33: r = 8'd72;  8'h43: r = 8'd73;
        8'h3B: r = 8'd74;  8'h42: r = 8'd75;  8'h4B: r = 8'd76;
        8'h3A: r = 8'd77;  8'h31: r = 8'd78;  8'h44: r = 8'd79;
        8'h4D: r = 8'd80;  8'h15: r = 8'd81;  8'h2D: r = 8'd82;
        8'h1B: r = 8'd83;  8'h2C: r = 8'd84;  8'h3C: r = 8'd85;
        8'h2A: r = 8'd86;  8'h1D: r = 8'd87;  8'h22: r = 8'd88;
        8'h35: r = 8'd89;  8'h1A: r = 8'd90;
        8'h45: r = 8'd48;  8'h16: r = 8'd49;  8'h1E: r = 8'd50;
        8'h26: r = 8'd51;  8'h25: r = 8'd52;  8'h2E: r = 8'd53;
        8'h36: r = 8'd54;  8'h3D: r = 8'd55;  8'h3E: r = 8'd56;
        8'h46: r = 8'd57;
        8'h29: r = 8'd32;   // space
        8'h5A: r = 8'd128;  // Enter
        8'h66: r = 8'd129;  // Backspace
        8'h76: r = 8'd140;  // Esc
        8'h05: r = 8'd141;  8'h06: r = 8'd142;  8'h04: r = 8'd143;
        8'h0C: r = 8'd144;  8'h03: r = 8'd145;  8'h0B: r = 8'd146;
        8'h83: r = 8'd147;  8'h0A: r = 8'd148;  8'h01: r = 8'd149;
        8'h09: r = 8'd150;  8'h78: r = 8'd151;  8'h07: r = 8'd152;
        8'h0E: r = 8'd96;   // `
        8'h4E: r = 8'd45;   // -
        8'h55: r = 8'd61;   // =
        8'h54: r = 8'd91;   // [
        8'h5B: r = 8'd93;   // ]
        8'h5D: r = 8'd92;   // backslash
        8'h4C: r = 8'd59;   // ;
        8'h52: r = 8'd39;   // '
        8'h41: r = 8'd44;   // ,
        8'h49: r = 8'd46;   // .
        8'h4A: r = 8'd47;   // /
        default: r = 8'd0;
      endcase
    end
    return r;
  endfunction

  // --------------------------------------------------------------------------
  // Input synchronisers (reset to the idle-high line level)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= ps2_clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_data;
      dat_s2_q <= dat_s1_q;
    end
  end

  // --------------------------------------------------------------------------
  // Glitch filter: a new ps2_clk level must persist FILTER_LEN consecutive
  // cycles; any return to the current level restarts the count.
  // --------------------------------------------------------------------------
  always_comb begin
    clk_filt_d = clk_filt_q;
    filt_cnt_d = '0;
    fall       = 1'b0;
    if (clk_s2_q != clk_filt_q) begin
      if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
        clk_filt_d = clk_s2_q;
        fall       = clk_filt_q & ~clk_s2_q;
      end else begin
        filt_cnt_d = filt_cnt_q + FW'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Frame FSM and timeout
  // --------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    parity_d      = parity_q;
    to_cnt_d      = to_cnt_q;
    byte_valid_d  = 1'b0;
    frame_error_d = 1'b0;

    if (fall) begin
      to_cnt_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (!dat_s2_q) begin
            state_d   = ST_DATA;
            bit_cnt_d = 3'd0;
          end else begin
            frame_error_d = 1'b1;
          end
        end
        ST_DATA: begin
          shift_d = {dat_s2_q, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        ST_PARITY: begin
          parity_d = dat_s2_q;
          state_d  = ST_STOP;
        end
        ST_STOP: begin
          // Odd parity over data + parity bit, plus a high stop bit.
          if (dat_s2_q && (^{shift_q, parity_q})) begin
            byte_valid_d = 1'b1;
          end else begin
            frame_error_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
        state_d       = ST_IDLE;
        frame_error_d = 1'b1;
        to_cnt_d      = '0;
      end else begin
        to_cnt_d = to_cnt_q + TW'(1);
      end
    end else begin
      to_cnt_d = '0;
    end
  end

  // --------------------------------------------------------------------------
  // Make/break decode. The received byte stays in shift_q while byte_valid
  // is high because the next fall is at least FILTER_LEN cycles away.
  // --------------------------------------------------------------------------
  assign mapped     = map_code(ext_q, shift_q);
  assign mapped_ext = {{(WIDTH-8){1'b0}}, mapped};

  always_comb begin
    ext_d      = ext_q;
    brk_d      = brk_q;
    key_code_d = key_code_q;
    if (frame_error_q) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (byte_valid_q) begin
      case (shift_q)
        8'hE0: ext_d = 1'b1;
        8'hF0: brk_d = 1'b1;
        8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: begin
          // Device status/ack bytes carry no key information.
        end
        default: begin
          ext_d = 1'b0;
          brk_d = 1'b0;
          if (!brk_q) begin
            if (mapped != 8'd0) key_code_d = mapped_ext;
          end else if ((mapped != 8'd0) && (mapped_ext == key_code_q)) begin
            key_code_d = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_filt_q    <= 1'b1;
      filt_cnt_q    <= '0;
      state_q       <= ST_IDLE;
      bit_cnt_q     <= 3'd0;
      shift_q       <= 8'd0;
      parity_q      <= 1'b0;
      to_cnt_q      <= '0;
      byte_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
      ext_q         <= 1'b0;
      brk_q         <= 1'b0;
      key_code_q    <= '0;
    end else begin
      clk_filt_q    <= clk_filt_d;
      filt_cnt_q    <= filt_cnt_d;
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      parity_q      <= parity_d;
      to_cnt_q      <= to_cnt_d;
      byte_valid_q  <= byte_valid_d;
      frame_error_q <= frame_error_d;
      ext_q         <= ext_d;
      brk_q         <= brk_d;
      key_code_q    <= key_code_d;
    end
  end

  assign key_code    = key_code_q;
  assign frame_error = frame_error_q;

endmodule
`default_nettype wire
